recip_float_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one reciprocal_float unit among N_REQ requesters.
- Per transaction it:
  - selects a requester and latches its IEEE-754 single operand;
  - pulses the unit's start and waits for its done;
  - returns the result, zero flag or error to the granted requester with a one-cycle ack.
- A watchdog pulses a reset into the unit if done never arrives, so a hung CORDIC cannot stall the requesters.

---
 rtl/recip_float_arbiter_pkg.sv | 11 +
 rtl/recip_float_arbiter_if.sv | 27 ++
 rtl/recip_float_arbiter_rr_priority_pick.sv | 17 +
 rtl/recip_float_arbiter.sv | 94 +++++++++
 tb/tb_recip_float_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/recip_float_arbiter_pkg.sv
// recip_float_arbiter_pkg: shared state encoding and FP constants for the reciprocal arbiter
package recip_float_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    TOUT  = 3'd4
  } state_t;
  localparam logic [31:0] FP_ZERO = 32'h0;
endpackage

// File: rtl/recip_float_arbiter_if.sv
// recip_float_arbiter_if: requester and reciprocal-unit signals shared by the arbiter
interface recip_float_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_operand;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       res_out;
  logic                    res_zero;
  logic                    res_err;
  logic                    busy;
  logic                    unit_start;
  logic [DATA_W-1:0]       unit_operand;
  logic                    unit_rst;
  logic                    unit_done;
  logic [DATA_W-1:0]       unit_result;
  logic                    unit_zero;
  modport master (
    output req, req_operand, unit_done, unit_result, unit_zero,
    input  ack, res_out, res_zero, res_err, busy, unit_start, unit_operand, unit_rst
  );
  modport slave (
    input  req, req_operand, unit_done, unit_result, unit_zero,
    output ack, res_out, res_zero, res_err, busy, unit_start, unit_operand, unit_rst
  );
endinterface

// File: rtl/recip_float_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request at or above rr_ptr, wrapping around
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);
  always_comb begin
    grant_idx = '0;
    any_req   = |req;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N_REQ]) grant_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
  end
endmodule

// File: rtl/recip_float_arbiter.sv
// recip_float_arbiter: round-robin sharing of one reciprocal unit with watchdog abort
module recip_float_arbiter
  import recip_float_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input logic clk,
  input logic rst,
  recip_float_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d, rr_q, rr_d, pick;
  logic [DATA_W-1:0] opnd_q, opnd_d, res_q, res_d;
  logic              zero_q, zero_d, err_q, err_d, any;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  rr_priority_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(bus.req), .rr_ptr(rr_q), .grant_idx(pick), .any_req(any)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (any) begin
        grant_d = pick;
        opnd_d  = bus.req_operand[pick*DATA_W +: DATA_W];
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.unit_done) begin
          res_d   = bus.unit_result;
          zero_d  = bus.unit_zero;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = TOUT;
      end
      TOUT: begin
        res_d   = FP_ZERO;
        zero_d  = 1'b0;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rr_d    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Every output decodes flop state only, so nothing combinational reaches the requesters.
  assign bus.ack          = (state_q == RESP) ? N_REQ'(1) << grant_q : '0;
  assign bus.res_out      = (state_q == RESP) ? res_q : FP_ZERO;
  assign bus.res_zero     = (state_q == RESP) && zero_q;
  assign bus.res_err      = (state_q == RESP) && err_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.unit_start   = state_q == ISSUE;
  assign bus.unit_rst     = state_q == TOUT;
  assign bus.unit_operand = opnd_q;
endmodule

// File: tb/tb_recip_float_arbiter.sv
// tb_recip_float_arbiter: directed vectors and corner sequences against a behavioural unit model
module tb_recip_float_arbiter;
  localparam int N = 4;
  localparam int TMO = 64;
  logic clk = 0;
  logic rst = 1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lat_m = 1;
  bit   hang_m = 0;
  recip_float_arbiter_if #(.N_REQ(N), .DATA_W(32)) bus ();
  recip_float_arbiter #(.N_REQ(N), .DATA_W(32), .TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rcp(input logic [31:0] op);
    rcp = (op[30:0] == 0) ? 32'h7F800000 : {op[31], 8'd254 - op[30:23], 23'd0};
  endfunction

  logic        act;
  int          cd;
  logic [31:0] opm;
  always @(posedge clk) begin
    if (rst || bus.unit_rst) begin
      act <= 0;
      cd <= 0;
      opm <= 0;
      bus.unit_done <= 0;
      bus.unit_result <= 0;
      bus.unit_zero <= 0;
    end else begin
      bus.unit_done <= 0;
      if (bus.unit_start) begin
        act <= 1;
        cd <= lat_m;
        opm <= bus.unit_operand;
      end else if (act && !hang_m) begin
        if (cd <= 1) begin
          bus.unit_done <= 1;
          bus.unit_result <= rcp(opm);
          bus.unit_zero <= (opm[30:0] == 0);
          act <= 0;
        end else cd <= cd - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output logic [31:0] r, output logic z, output logic e,
                          output int starts, output int rsts, output int s_cyc, output int r_cyc,
                          output int a_cyc);
    bit to;
    to = 1; a = 0; r = 0; z = 0; e = 0;
    starts = 0; rsts = 0; s_cyc = 0; r_cyc = 0; a_cyc = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.unit_start) begin starts++; s_cyc = cyc; end
      if (bus.unit_rst) begin rsts++; r_cyc = cyc; end
      if (|bus.ack) begin
        a = bus.ack; r = bus.res_out; z = bus.res_zero; e = bus.res_err; a_cyc = cyc;
        to = 0;
        break;
      end
    end
    chk("ack_timeout", {31'd0, to}, 32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] op;
    int          lat;
    bit          hang;
    logic [31:0] exp_res;
    bit          exp_zero;
    bit          exp_err;
  } vec_t;
  vec_t vecs[5];

  logic [N-1:0] a;
  logic [31:0]  r;
  logic         z, e;
  int           st, rs, sc, rc, ac, nacks;
  int           ord[5];
  logic [31:0]  rr_exp[5];

  initial begin
    vecs[0] = '{1, 32'h40000000, 20, 0, 32'h3F000000, 0, 0};
    vecs[1] = '{0, 32'h00000000, 5,  0, 32'h7F800000, 1, 0};
    vecs[2] = '{2, 32'h41000000, 63, 0, 32'h3E000000, 0, 0};
    vecs[3] = '{3, 32'h3F800000, 1,  1, 32'h00000000, 0, 1};
    vecs[4] = '{3, 32'h40800000, 3,  0, 32'h3E800000, 0, 0};
    ord = '{0, 1, 2, 3, 0};
    rr_exp = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3F800000};
    bus.req = '0;
    bus.req_operand = '0;
    tick(); tick();
    rst = 0;
    chk("rst_ack", {28'd0, bus.ack}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_res", bus.res_out, 0);
    chk("rst_start", {31'd0, bus.unit_start}, 0);
    chk("rst_urst", {31'd0, bus.unit_rst}, 0);
    chk("rst_operand", bus.unit_operand, 0);

    for (int i = 0; i < 5; i++) begin
      lat_m = vecs[i].lat;
      hang_m = vecs[i].hang;
      bus.req = '0;
      bus.req[vecs[i].idx] = 1'b1;
      bus.req_operand[vecs[i].idx*32 +: 32] = vecs[i].op;
      wait_ack(a, r, z, e, st, rs, sc, rc, ac);
      chk($sformatf("v%0d_ack", i), {28'd0, a}, 32'd1 << vecs[i].idx);
      chk($sformatf("v%0d_res", i), r, vecs[i].exp_res);
      chk($sformatf("v%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_starts", i), st, 1);
      chk($sformatf("v%0d_urst", i), rs, {31'd0, vecs[i].exp_err});
      if (vecs[i].hang) chk($sformatf("v%0d_urst_cyc", i), rc - sc, TMO + 1);
      else chk($sformatf("v%0d_lat", i), ac - sc, vecs[i].lat + 2);
      bus.req = '0;
      tick();
      chk($sformatf("v%0d_ack_once", i), {28'd0, bus.ack}, 0);
      chk($sformatf("v%0d_busy_off", i), {31'd0, bus.busy}, 0);
      chk($sformatf("v%0d_res_idle", i), bus.res_out, 0);
    end

    // Round robin with every requester held high.
    rst = 1; tick(); rst = 0;
    lat_m = 4; hang_m = 0;
    bus.req_operand = {32'h41000000, 32'h40800000, 32'h40000000, 32'h3F800000};
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, r, z, e, st, rs, sc, rc, ac);
      chk($sformatf("rr%0d_ack", k), {28'd0, a}, 32'd1 << ord[k]);
      chk($sformatf("rr%0d_res", k), r, rr_exp[k]);
    end
    bus.req = '0;
    tick(); tick();

    // Operand changed after grant must not affect the result.
    lat_m = 10;
    bus.req_operand[2*32 +: 32] = 32'h40000000;
    bus.req = 4'b0100;
    tick();
    chk("chg_start", {31'd0, bus.unit_start}, 1);
    chk("chg_operand", bus.unit_operand, 32'h40000000);
    bus.req_operand[2*32 +: 32] = 32'h41000000;
    wait_ack(a, r, z, e, st, rs, sc, rc, ac);
    chk("chg_ack", {28'd0, a}, 32'h4);
    chk("chg_res", r, 32'h3F000000);
    bus.req = '0;
    tick();

    // Reset in WAIT aborts silently and clears rr_ptr.
    lat_m = 30;
    bus.req_operand[1*32 +: 32] = 32'h40000000;
    bus.req = 4'b0010;
    tick();
    for (int k = 0; k < 5; k++) tick();
    rst = 1;
    tick();
    rst = 0;
    bus.req = '0;
    chk("mid_busy", {31'd0, bus.busy}, 0);
    chk("mid_ack", {28'd0, bus.ack}, 0);
    chk("mid_start", {31'd0, bus.unit_start}, 0);
    nacks = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (|bus.ack) nacks++;
    end
    chk("mid_no_ack", nacks, 0);
    lat_m = 2;
    bus.req_operand[0*32 +: 32] = 32'h3F800000;
    bus.req_operand[3*32 +: 32] = 32'h41000000;
    bus.req = 4'b1001;
    wait_ack(a, r, z, e, st, rs, sc, rc, ac);
    chk("mid_rr_ack", {28'd0, a}, 32'h1);
    chk("mid_rr_res", r, 32'h3F800000);
    bus.req = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
